// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between a synchronous FIFO and its consumer.
interface fifo_uart_tx_if #(
  parameter int unsigned DATA_WIDTH = 8
);

  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_rd_en;

  // Consumer side: pops words when it is ready for them.
  modport master (
    input  fifo_empty,
    input  fifo_dout,
    output fifo_rd_en
  );

  // FIFO side: presents data and the empty flag.
  modport slave (
    output fifo_empty,
    output fifo_dout,
    input  fifo_rd_en
  );

endinterface

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a FIFO and serialises each as a UART frame on txd:
// start bit, LSB-first data, optional even parity, 1 or 2 stop bits.
module fifo_uart_tx #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           n_rst,
  input  logic           enable,
  fifo_uart_tx_if.master fifo,
  output logic           txd,
  output logic           busy,
  output logic           frame_done
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned CNT_W  = $clog2(DATA_WIDTH + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]  STOP_LAST = CNT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state;
  logic [BAUD_W-1:0]     baud;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic                  parity;
  logic                  baud_end;

  // Last clock of the current serial bit.
  assign baud_end = (baud == BAUD_LAST);

  // Frame sequencer; every output is registered alongside the state it belongs to.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state           <= IDLE;
      txd             <= 1'b1;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
      fifo.fifo_rd_en <= 1'b0;
      baud            <= '0;
      bit_cnt         <= '0;
      shift           <= '0;
      parity          <= 1'b0;
    end else begin
      fifo.fifo_rd_en <= 1'b0;
      frame_done      <= 1'b0;
      case (state)
        IDLE: begin
          txd     <= 1'b1;
          baud    <= '0;
          bit_cnt <= '0;
          if (enable && !fifo.fifo_empty) begin
            state           <= READ;
            fifo.fifo_rd_en <= 1'b1;
            busy            <= 1'b1;
          end
        end

        // Pop strobe is high for exactly this one cycle.
        READ: begin
          state <= LOAD;
        end

        // Read latency is one cycle, so fifo_dout is valid now.
        LOAD: begin
          shift  <= fifo.fifo_dout;
          parity <= ^fifo.fifo_dout;
          state  <= START;
          txd    <= 1'b0;
          baud   <= '0;
        end

        START: begin
          if (baud_end) begin
            state   <= DATA;
            txd     <= shift[0];
            baud    <= '0;
            bit_cnt <= '0;
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end

        // shift[0] is on the line; present shift[1] before the shift lands.
        DATA: begin
          if (baud_end) begin
            baud <= '0;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                state <= PARITY;
                txd   <= parity;
              end else begin
                state <= STOP;
                txd   <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
              shift   <= shift >> 1;
              txd     <= shift[1];
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end

        PARITY: begin
          if (baud_end) begin
            state   <= STOP;
            txd     <= 1'b1;
            baud    <= '0;
            bit_cnt <= '0;
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end

        // frame_done is set one edge early so it is high in the final stop cycle.
        STOP: begin
          txd <= 1'b1;
          if ((bit_cnt == STOP_LAST) && (baud == BAUD_PRE)) begin
            frame_done <= 1'b1;
          end
          if (baud_end) begin
            baud <= '0;
            if (bit_cnt == STOP_LAST) begin
              state   <= IDLE;
              busy    <= 1'b0;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          txd   <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (plain 8N1 and 8E2), FIFO models,
// a frame decoder per instance and a byte scoreboard.
module tb_fifo_uart_tx;

  localparam int unsigned DW  = 8;
  localparam int unsigned CPB = 4;

  logic clk = 1'b0;
  logic n_rst;
  logic en_a;
  logic en_b;
  logic txd_a, busy_a, fd_a;
  logic txd_b, busy_b, fd_b;

  fifo_uart_tx_if #(.DATA_WIDTH(DW)) ifa ();
  fifo_uart_tx_if #(.DATA_WIDTH(DW)) ifb ();

  fifo_uart_tx #(
    .DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)
  ) dut_a (
    .clk(clk), .n_rst(n_rst), .enable(en_a), .fifo(ifa.master),
    .txd(txd_a), .busy(busy_a), .frame_done(fd_a)
  );

  fifo_uart_tx #(
    .DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(2)
  ) dut_b (
    .clk(clk), .n_rst(n_rst), .enable(en_b), .fifo(ifb.master),
    .txd(txd_b), .busy(busy_b), .frame_done(fd_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [DW-1:0] fa[$];
  logic [DW-1:0] fb[$];
  logic [DW-1:0] sba[$];
  logic [DW-1:0] sbb[$];

  int rd_cnt[2]    = '{0, 0};
  int busy_cnt[2]  = '{0, 0};
  int low_cnt[2]   = '{0, 0};
  int rd_cyc[2]    = '{0, 0};
  int frames[2]    = '{0, 0};
  int aborts[2]    = '{0, 0};
  int start_cyc[2] = '{0, 0};
  int end_cyc[2]   = '{0, 0};
  int gap[2]       = '{0, 0};

  // Single point of comparison and error reporting.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO models with one-cycle read latency.
  always @(posedge clk) begin
    if (ifa.fifo_rd_en && fa.size() > 0) ifa.fifo_dout <= fa.pop_front();
    ifa.fifo_empty <= (fa.size() == 0);
    if (ifb.fifo_rd_en && fb.size() > 0) ifb.fifo_dout <= fb.pop_front();
    ifb.fifo_empty <= (fb.size() == 0);
  end

  // Event counters sampled away from the active edge.
  always @(negedge clk) begin
    if (ifa.fifo_rd_en === 1'b1) begin rd_cnt[0]++; rd_cyc[0] = cyc; end
    if (ifb.fifo_rd_en === 1'b1) begin rd_cnt[1]++; rd_cyc[1] = cyc; end
    if (busy_a === 1'b1) busy_cnt[0]++;
    if (busy_b === 1'b1) busy_cnt[1]++;
    if (txd_a === 1'b0) low_cnt[0]++;
    if (txd_b === 1'b0) low_cnt[1]++;
  end

  function automatic logic txd_of(input int w);
    return (w == 0) ? txd_a : txd_b;
  endfunction

  function automatic logic fd_of(input int w);
    return (w == 0) ? fd_a : fd_b;
  endfunction

  function automatic bit sb_pop(input int w, output logic [DW-1:0] b);
    b = '0;
    if (w == 0 && sba.size() > 0) begin b = sba.pop_front(); return 1'b1; end
    if (w == 1 && sbb.size() > 0) begin b = sbb.pop_front(); return 1'b1; end
    return 1'b0;
  endfunction

  task automatic push_byte(input int w, input logic [DW-1:0] b);
    if (w == 0) begin fa.push_back(b); sba.push_back(b); end
    else        begin fb.push_back(b); sbb.push_back(b); end
  endtask

  // Decodes one frame per falling edge of txd and checks it against the scoreboard.
  task automatic monitor(input int w);
    int nb, total, par, stop_n, fdn, fdpos;
    logic [15:0]   lv;
    logic [1:0]    stopv;
    logic [DW-1:0] expb;
    logic [DW-1:0] data;
    bit stable, aborted, ok;
    forever begin
      @(negedge clk);
      if (n_rst === 1'b1 && txd_of(w) === 1'b0) begin
        par    = (w == 1) ? 1 : 0;
        stop_n = (w == 1) ? 2 : 1;
        nb     = 1 + DW + par + stop_n;
        total  = nb * CPB;
        lv = '0; stopv = '0; stable = 1'b1; aborted = 1'b0; fdn = 0; fdpos = -1;
        start_cyc[w] = cyc;
        gap[w] = cyc - end_cyc[w] - 1;
        for (int c = 0; c < total; c++) begin
          if (c > 0) @(negedge clk);
          if (n_rst !== 1'b1) begin aborted = 1'b1; break; end
          if (c % CPB == 0) lv[c / CPB] = txd_of(w);
          else if (txd_of(w) !== lv[c / CPB]) stable = 1'b0;
          if (fd_of(w) === 1'b1) begin fdn++; fdpos = c; end
        end
        if (aborted) begin
          aborts[w]++;
          void'(sb_pop(w, expb));
        end else begin
          end_cyc[w] = cyc;
          ok = sb_pop(w, expb);
          check("sb_has_entry", 32'(ok), 32'd1);
          data = lv[DW:1];
          check("data", 32'(data), 32'(expb));
          if (par != 0) check("parity", 32'(lv[DW+1]), 32'(^expb));
          for (int i = 0; i < stop_n; i++) stopv[i] = lv[1 + DW + par + i];
          check("stop_bits", 32'(stopv), 32'((1 << stop_n) - 1));
          check("bit_stable", 32'(stable), 32'd1);
          check("frame_done_count", 32'(fdn), 32'd1);
          check("frame_done_pos", 32'(fdpos), 32'(total - 1));
          frames[w]++;
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic wait_frames(input int w, input int n, input int budget);
    int k;
    k = 0;
    while (frames[w] < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("frame_timeout", 32'(frames[w] >= n), 32'd1);
  endtask

  task automatic wait_start(input int w, input int budget);
    int k;
    k = 0;
    while (txd_of(w) !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("start_timeout", 32'(txd_of(w) === 1'b0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b_rd, b_busy, b_low, f0, b_ab;
    n_rst = 1'b0;
    en_a  = 1'b0;
    en_b  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd_a), 32'd1);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_rd_en", 32'(ifa.fifo_rd_en), 32'd0);
    check("rst_frame_done", 32'(fd_a), 32'd0);
    check("rst_txd_b", 32'(txd_b), 32'd1);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte 0xA5, 8N1.
    b_rd = rd_cnt[0]; b_busy = busy_cnt[0]; f0 = frames[0];
    push_byte(0, 8'hA5);
    en_a = 1'b1;
    wait_frames(0, f0 + 1, 200);
    repeat (5) @(negedge clk);
    check("t1_rd_pulses", 32'(rd_cnt[0] - b_rd), 32'd1);
    check("t1_busy_cycles", 32'(busy_cnt[0] - b_busy), 32'd42);
    check("t1_rd_to_start", 32'(start_cyc[0] - rd_cyc[0]), 32'd2);

    // Empty FIFO with enable high: nothing happens.
    b_rd = rd_cnt[0]; b_busy = busy_cnt[0]; b_low = low_cnt[0];
    repeat (100) @(negedge clk);
    check("t2_rd_pulses", 32'(rd_cnt[0] - b_rd), 32'd0);
    check("t2_busy_cycles", 32'(busy_cnt[0] - b_busy), 32'd0);
    check("t2_txd_low_cycles", 32'(low_cnt[0] - b_low), 32'd0);

    // Even parity, two stop bits: 0x07 -> parity 1, 0x03 -> parity 0.
    b_rd = rd_cnt[1]; b_busy = busy_cnt[1];
    push_byte(1, 8'h07);
    push_byte(1, 8'h03);
    en_b = 1'b1;
    wait_frames(1, 2, 400);
    repeat (5) @(negedge clk);
    check("t3_rd_pulses", 32'(rd_cnt[1] - b_rd), 32'd2);
    check("t3_busy_cycles", 32'(busy_cnt[1] - b_busy), 32'd100);

    // Back-to-back 0x11, 0x22: three idle-high cycles between frames.
    en_a = 1'b0;
    repeat (2) @(negedge clk);
    b_rd = rd_cnt[0]; f0 = frames[0];
    push_byte(0, 8'h11);
    push_byte(0, 8'h22);
    en_a = 1'b1;
    wait_frames(0, f0 + 2, 400);
    repeat (3) @(negedge clk);
    check("t4_gap", 32'(gap[0]), 32'd3);
    check("t4_rd_pulses", 32'(rd_cnt[0] - b_rd), 32'd2);

    // enable dropped mid-frame: current frame finishes, no further pop.
    en_a = 1'b0;
    repeat (2) @(negedge clk);
    b_rd = rd_cnt[0]; f0 = frames[0];
    push_byte(0, 8'h5A);
    push_byte(0, 8'h3C);
    en_a = 1'b1;
    wait_start(0, 50);
    repeat (CPB + 2 * CPB) @(negedge clk);
    en_a = 1'b0;
    wait_frames(0, f0 + 1, 200);
    repeat (60) @(negedge clk);
    check("t5_rd_pulses_held", 32'(rd_cnt[0] - b_rd), 32'd1);
    check("t5_frames_held", 32'(frames[0] - f0), 32'd1);
    check("t5_fifo_left", 32'(fa.size()), 32'd1);
    en_a = 1'b1;
    wait_frames(0, f0 + 2, 200);
    check("t5_rd_pulses_resumed", 32'(rd_cnt[0] - b_rd), 32'd2);

    // Reset in data bit 3 of 0xC3 (a zero bit), then 0x96 sent cleanly.
    en_a = 1'b0;
    repeat (2) @(negedge clk);
    f0 = frames[0]; b_ab = aborts[0];
    push_byte(0, 8'hC3);
    push_byte(0, 8'h96);
    en_a = 1'b1;
    wait_start(0, 50);
    repeat (CPB + 3 * CPB + 2) @(negedge clk);
    check("t6_pre_reset_txd", 32'(txd_a), 32'd0);
    #1 n_rst = 1'b0;
    #1;
    check("t6_rst_txd", 32'(txd_a), 32'd1);
    check("t6_rst_busy", 32'(busy_a), 32'd0);
    check("t6_rst_rd_en", 32'(ifa.fifo_rd_en), 32'd0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    wait_frames(0, f0 + 1, 300);
    repeat (5) @(negedge clk);
    check("t6_aborted", 32'(aborts[0] - b_ab), 32'd1);
    check("t6_sb_drained", 32'(sba.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
